// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display scheduler.
// The SEG_SCHED_LEADING_ZERO_BLANK_EN build uses top_digit() to blank leading zeros.
package seg_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int unsigned DIGITS    = 4;
  localparam logic [3:0]  SEL_BLANK = 4'b1111;

  // Active-low one-hot digit enable for a scan index.
  function automatic logic [3:0] digit_sel(input logic [1:0] idx);
    digit_sel = ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] idx);
    nibble_of = v[{idx, 2'b00} +: 4];
  endfunction

  // Index of the most significant non-zero nibble; 0 for an all-zero value.
  function automatic logic [1:0] top_digit(input logic [15:0] v);
    top_digit = 2'd0;
    for (int d = 1; d < int'(DIGITS); d++) begin
      if (v[4*d +: 4] != 4'h0) top_digit = 2'(d);
    end
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin finder: first requester after ptr (wrapping),
// with ptr itself considered last only when include_ptr is set.
module seg_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 include_ptr,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!found && req[IW'(cand)] && ((off != N) || include_ptr)) begin
        found          = 1'b1;
        idx            = IW'(cand);
        pick[IW'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares one 4-digit multiplexed seven-segment display between requesters.
// Optional build macro SEG_SCHED_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DWELL_FRAMES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [16*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [3:0]              o_nibble,
  output logic [3:0]              o_digit_sel,
  output logic                    o_frame_start
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int unsigned IW = $clog2(NUM_REQ);

  state_t          state;
  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [DW-1:0]   dwell;
  logic [IW-1:0]   ptr;
  logic [15:0]     snap;

  logic                tick;
  logic                dwell_done;
  logic                keep;
  logic                include_ptr;
  logic                start_frame;
  logic [1:0]          idx_next;
  logic [1:0]          show_limit;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [IW-1:0]       next_idx;
  logic [NUM_REQ-1:0]  next_onehot;
  logic [15:0]         next_data;

  assign tick        = (presc == PW'(SCAN_DIV - 1));
  assign dwell_done  = (dwell == DW'(DWELL_FRAMES - 1));
  assign idx_next    = idx + 2'd1;

  // Owner keeps the display for another frame while its dwell runs and it still requests.
  assign keep        = (state == SHOW) && !dwell_done && i_req[ptr];
  assign include_ptr = (state == IDLE) || dwell_done;

  seg_rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req         (i_req),
    .ptr         (ptr),
    .include_ptr (include_ptr),
    .pick        (pick_onehot),
    .idx         (pick_idx),
    .found       (pick_found)
  );

  assign start_frame = (state == IDLE) ? pick_found
                                       : ((idx == 2'd3) && (keep || pick_found));
  assign next_idx    = keep ? ptr : pick_idx;
  assign next_onehot = keep ? o_grant : pick_onehot;

  always_comb begin
    next_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (next_idx == IW'(k)) next_data = i_req_data[16*k +: 16];
    end
  end

`ifdef SEG_SCHED_LEADING_ZERO_BLANK_EN
  assign show_limit = top_digit(snap);
`else
  assign show_limit = 2'd3;
`endif

  // Prescaler, scan index, dwell and ownership; all display updates land on tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      presc         <= '0;
      idx           <= '0;
      dwell         <= '0;
      ptr           <= IW'(NUM_REQ - 1);
      snap          <= '0;
      o_grant       <= '0;
      o_nibble      <= '0;
      o_digit_sel   <= SEL_BLANK;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      presc         <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (start_frame) begin
          state         <= SHOW;
          ptr           <= next_idx;
          snap          <= next_data;
          idx           <= '0;
          dwell         <= keep ? dwell + 1'b1 : '0;
          o_grant       <= next_onehot;
          o_nibble      <= next_data[3:0];
          o_digit_sel   <= digit_sel(2'd0);
          o_frame_start <= 1'b1;
        end else if ((state == SHOW) && (idx != 2'd3)) begin
          idx           <= idx_next;
          o_nibble      <= nibble_of(snap, idx_next);
          o_digit_sel   <= (idx_next > show_limit) ? SEL_BLANK : digit_sel(idx_next);
        end else begin
          state         <= IDLE;
          dwell         <= '0;
          o_grant       <= '0;
          o_nibble      <= '0;
          o_digit_sel   <= SEL_BLANK;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized bench for seg_display_scheduler against a frame-level reference model.
module tb_seg_display_scheduler;

  localparam int NR = 4;
  localparam int SD = 4;
  localparam int DF = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [16*NR-1:0]  data;
  logic [NR-1:0]     grant;
  logic [3:0]        nib;
  logic [3:0]        sel;
  logic              fs;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int            m_cnt, m_owner, m_digit, m_frames, m_last;
  logic [15:0]   m_snap;
  logic [NR-1:0] e_grant;
  logic [3:0]    e_nib, e_sel;
  logic          e_fs;

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .NUM_REQ      (NR),
    .SCAN_DIV     (SD),
    .DWELL_FRAMES (DF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_data    (data),
    .o_grant       (grant),
    .o_nibble      (nib),
    .o_digit_sel   (sel),
    .o_frame_start (fs)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_next(input int from, input bit incl);
    for (int k = 1; k <= NR; k++) begin
      int i = (from + k) % NR;
      if (k == NR && !incl) continue;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_owner = -1; m_digit = 0; m_frames = 0; m_last = NR - 1; m_snap = '0;
    e_grant = '0; e_nib = '0; e_sel = 4'hF; e_fs = 1'b0;
  endtask

  task automatic model_show();
    int top;
    e_nib = 4'((m_snap >> (4 * m_digit)) & 16'hF);
    e_sel = 4'(15 - (1 << m_digit));
    top = 3;
`ifdef SEG_SCHED_LEADING_ZERO_BLANK_EN
    top = 0;
    for (int d = 1; d < 4; d++) if (((m_snap >> (4 * d)) & 16'hF) != 0) top = d;
`endif
    if (m_digit > top) e_sel = 4'hF;
  endtask

  task automatic model_start(input int p);
    m_owner = p; m_last = p; m_digit = 0;
    m_snap  = data[16*p +: 16];
    e_grant = NR'(1) << p;
    e_fs    = 1'b1;
    model_show();
  endtask

  task automatic model_edge();
    bit tick;
    int p;
    e_fs  = 1'b0;
    tick  = (m_cnt == SD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (!tick) return;
    if (m_owner < 0) begin
      p = find_next(m_last, 1'b1);
      if (p >= 0) begin m_frames = 0; model_start(p); end
    end else if (m_digit < 3) begin
      m_digit++;
      model_show();
    end else if (m_frames < DF - 1 && req[m_owner]) begin
      m_frames++;
      model_start(m_owner);
    end else begin
      p = find_next(m_owner, m_frames == DF - 1);
      if (p >= 0) begin
        m_frames = 0;
        model_start(p);
      end else begin
        m_owner = -1; e_grant = '0; e_nib = '0; e_sel = 4'hF;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      check_eq("grant", 32'(grant), 32'(e_grant));
      check_eq("nibble", 32'(nib), 32'(e_nib));
      check_eq("digit_sel", 32'(sel), 32'(e_sel));
      check_eq("frame_start", 32'(fs), 32'(e_fs));
      @(negedge clk);
    end
  endtask

  task automatic wait_for(input string tag, input int own, input int dig);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (m_owner == own && m_digit == dig) ok = 1'b1;
      else step(1);
    end
    check_eq({"reach_", tag}, 32'(ok), 32'd1);
  endtask

  task automatic set_data(input int k, input logic [15:0] v);
    data[16*k +: 16] = v;
  endtask

  function automatic logic [15:0] rand_val();
    if ($urandom_range(0, 3) == 0) return 16'h0000;
    return 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
  endfunction

  initial begin
    rst = 1'b1; req = '0; data = '0;
    model_reset();
    #2;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'hF);
    check_eq("rst_nibble", 32'(nib), 32'd0);
    check_eq("rst_fs", 32'(fs), 32'd0);
    @(negedge clk);
    step(2);
    rst = 1'b0;

    // single owner, steady scan
    set_data(0, 16'h1234); req = 4'b0001;
    step(80);

    // asynchronous reset in the middle of a frame
    wait_for("midframe", 0, 1);
    rst = 1'b1;
    #1;
    check_eq("async_grant", 32'(grant), 32'd0);
    check_eq("async_sel", 32'(sel), 32'hF);
    check_eq("async_nibble", 32'(nib), 32'd0);
    check_eq("async_fs", 32'(fs), 32'd0);
    model_reset();
    step(1);
    rst = 1'b0;
    step(40);

    // two requesters rotating on dwell expiry
    set_data(2, 16'h9876); req = 4'b0101;
    step(150);

    // data change mid-frame is held off until the next snapshot
    req = 4'b0001; set_data(0, 16'hABCD);
    wait_for("data_chg", 0, 1);
    set_data(0, 16'h5555);
    step(40);

    // owner drops during digit 2 with another request pending
    set_data(1, 16'h0F0F); req = 4'b0011;
    wait_for("owner_drop", 0, 2);
    req = 4'b0010;
    step(60);

    // everything drops
    req = 4'b0000;
    step(40);

    // leading-zero value
    set_data(0, 16'h00F0); req = 4'b0001;
    step(40);
    set_data(0, 16'h0000);
    step(40);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) req = NR'($urandom);
      if ($urandom_range(0, 2) == 0) set_data($urandom_range(0, NR - 1), rand_val());
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
